// File: rtl/pwl_arb_pkg.sv
// Shared types and helpers for the pwl evaluator arbiter.
package pwl_arb_pkg;

    // Tag id is sized for up to 256 requesters; users slice it to the index width.
    localparam int unsigned PWL_ARB_ID_W = 8;

    typedef struct packed {
        logic                    valid;
        logic [PWL_ARB_ID_W-1:0] id;
    } pwl_tag_t;

    function automatic logic [PWL_ARB_ID_W-1:0] next_rr_ptr(
        input logic [PWL_ARB_ID_W-1:0] ptr,
        input int unsigned             n_req
    );
        if (int'(ptr) >= int'(n_req) - 1) return '0;
        return ptr + 1'b1;
    endfunction

endpackage

// File: rtl/pwl_arb_rr.sv
// Round-robin candidate picker: first eligible index at or above ptr, wrapping.
module pwl_arb_rr
    import pwl_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]        eligible,
    input  logic [PWL_ARB_ID_W-1:0] ptr,
    output logic [PWL_ARB_ID_W-1:0] cand,
    output logic                    found
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    int unsigned idx;

    always_comb begin
        cand  = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && eligible[IW'(idx)]) begin
                found = 1'b1;
                cand  = PWL_ARB_ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/pwl_arbiter.sv
// Time-multiplexes one pwl evaluator among N_REQ requesters.
// Optional per-requester grant counters under `PWL_ARB_STATS_EN.
module pwl_arbiter
    import pwl_arb_pkg::*;
#(
    parameter int unsigned N_REQ         = 4,
    parameter int unsigned IN_WIDTH      = 16,
    parameter int unsigned OUT_WIDTH     = 16,
    parameter int unsigned SETTING_WIDTH = 2,
    parameter int unsigned PWL_LATENCY   = 1,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [N_REQ-1:0]                      req_valid,
    output logic [N_REQ-1:0]                      req_ready,
    input  logic [N_REQ-1:0][IN_WIDTH-1:0]        req_in,
    input  logic [N_REQ-1:0][SETTING_WIDTH-1:0]   req_setting,
    output logic [N_REQ-1:0]                      rsp_valid,
    input  logic [N_REQ-1:0]                      rsp_ready,
    output logic [N_REQ-1:0][OUT_WIDTH-1:0]       rsp_data,
    output logic [IN_WIDTH-1:0]                   pwl_in,
    output logic [SETTING_WIDTH-1:0]              pwl_setting,
    input  logic [OUT_WIDTH-1:0]                  pwl_out
`ifdef PWL_ARB_STATS_EN
    ,
    output logic [N_REQ-1:0][CNT_WIDTH-1:0]       grant_cnt
`endif
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]                busy_q;
    logic [N_REQ-1:0]                rsp_valid_q;
    logic [N_REQ-1:0][OUT_WIDTH-1:0] rsp_data_q;
    logic [N_REQ-1:0]                eligible;
    logic [PWL_ARB_ID_W-1:0]         ptr_q;
    logic [PWL_ARB_ID_W-1:0]         cand;
    logic                            found;
    logic                            inflight;
    logic                            grant;
    logic [SETTING_WIDTH-1:0]        held_q;
    pwl_tag_t                        tag_q [PWL_LATENCY];

    assign eligible = req_valid & ~busy_q;

    pwl_arb_rr #(.N_REQ(N_REQ)) u_rr (
        .eligible (eligible),
        .ptr      (ptr_q),
        .cand     (cand),
        .found    (found)
    );

    always_comb begin
        inflight = 1'b0;
        for (int unsigned s = 0; s < PWL_LATENCY; s++) inflight = inflight | tag_q[s].valid;
    end

    // An incompatible candidate stalls the whole arbiter rather than being skipped,
    // which keeps the rotation starvation-free.  Grant is masked while in reset.
    assign grant = rst_n && found &&
                   !(inflight && (req_setting[IW'(cand)] != held_q));

    always_comb begin
        req_ready   = '0;
        pwl_in      = '0;
        pwl_setting = inflight ? held_q : '0;
        if (grant) begin
            req_ready[IW'(cand)] = 1'b1;
            pwl_in               = req_in[IW'(cand)];
            pwl_setting          = req_setting[IW'(cand)];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q      <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            ptr_q       <= '0;
            held_q      <= '0;
            for (int unsigned s = 0; s < PWL_LATENCY; s++) tag_q[s] <= '0;
        end else begin
            for (int unsigned s = 1; s < PWL_LATENCY; s++) tag_q[s] <= tag_q[s-1];
            tag_q[0] <= '{valid: grant, id: cand};
            if (grant) begin
                held_q <= req_setting[IW'(cand)];
                ptr_q  <= next_rr_ptr(cand, N_REQ);
            end
            busy_q <= (busy_q & ~(rsp_valid_q & rsp_ready)) | req_ready;
            // Busy blocks re-issue until consumed, so capture never overwrites a pending result.
            if (tag_q[PWL_LATENCY-1].valid) begin
                rsp_valid_q <= (rsp_valid_q & ~rsp_ready) |
                               (N_REQ'(1) << IW'(tag_q[PWL_LATENCY-1].id));
                rsp_data_q[IW'(tag_q[PWL_LATENCY-1].id)] <= pwl_out;
            end else begin
                rsp_valid_q <= rsp_valid_q & ~rsp_ready;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

`ifdef PWL_ARB_STATS_EN
    logic [N_REQ-1:0][CNT_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (req_valid[i] && req_ready[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + 1'b1;
            end
        end
    end

    assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_pwl_arbiter.sv
// Self-checking bench for pwl_arbiter with a behavioural pwl (latency 1) and a spec-level model.
module tb_pwl_arbiter;

    localparam int N     = 4;
    localparam int CNT_W = 3;
    localparam int GL    = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0]       req_valid;
    logic [N-1:0]       req_ready;
    logic [N-1:0][15:0] req_in;
    logic [N-1:0][1:0]  req_setting;
    logic [N-1:0]       rsp_valid;
    logic [N-1:0]       rsp_ready;
    logic [N-1:0][15:0] rsp_data;
    logic [15:0]        pwl_in;
    logic [1:0]         pwl_setting;
    logic [15:0]        pwl_out;
`ifdef PWL_ARB_STATS_EN
    logic [N-1:0][CNT_W-1:0] grant_cnt;
`endif

    always #5 clk = ~clk;

    pwl_arbiter #(
        .N_REQ(N), .IN_WIDTH(16), .OUT_WIDTH(16), .SETTING_WIDTH(2),
        .PWL_LATENCY(1), .CNT_WIDTH(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_in(req_in), .req_setting(req_setting),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .pwl_in(pwl_in), .pwl_setting(pwl_setting), .pwl_out(pwl_out)
`ifdef PWL_ARB_STATS_EN
        , .grant_cnt(grant_cnt)
`endif
    );

    // Golden pwl: segment = in[15:12], offset = in[11:0].
    function automatic int pwl_bias(input logic [1:0] s, input logic [3:0] seg);
        return int'(s) * 1000 + int'(seg) * 64 - 500;
    endfunction
    function automatic int pwl_prod(input logic [15:0] x, input logic [1:0] s);
        int sl;
        sl = int'(s) * 3 + int'(x[15:12]) - 7;
        return (sl * int'(x[11:0])) >>> 4;
    endfunction
    function automatic logic [15:0] golden(input logic [15:0] x, input logic [1:0] s);
        return 16'(pwl_bias(s, x[15:12]) + pwl_prod(x, s));
    endfunction

    // Device stand-in: product uses setting at issue, bias uses setting at capture.
    logic [3:0] seg_q;
    int         prod_q;
    always_ff @(posedge clk) begin
        seg_q  <= pwl_in[15:12];
        prod_q <= pwl_prod(pwl_in, pwl_setting);
    end
    assign pwl_out = 16'(pwl_bias(pwl_setting, seg_q) + prod_q);

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int gid [GL];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Spec-level model state
    logic [N-1:0] m_busy, m_rspv;
    logic [15:0]  m_rspd [N];
    int           m_ptr, m_cnt [N];
    logic [1:0]   m_held;
    logic         pipe_v;
    int           pipe_id;
    logic [15:0]  pipe_res;

    initial begin : compare
        int act, cand, eg, idx;
        logic [N-1:0] exp_rr;
        logic [15:0]  exp_in;
        logic [1:0]   exp_set;
        forever begin
            @(negedge clk);
            cyc++;
            act = -1;
            for (int i = 0; i < N; i++) if (req_ready[i]) act = (act == -1) ? i : -2;
            if (cyc < GL) gid[cyc] = act;
            if (!rst_n) begin
                m_busy = '0; m_rspv = '0; m_ptr = 0; m_held = '0; pipe_v = 1'b0;
                for (int i = 0; i < N; i++) begin m_cnt[i] = 0; m_rspd[i] = '0; end
                chk("rst_req_ready", 64'(req_ready), 64'(0));
                chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
                chk("rst_pwl_in", 64'(pwl_in), 64'(0));
                chk("rst_pwl_setting", 64'(pwl_setting), 64'(0));
            end else begin
                cand = -1;
                for (int k = 0; k < N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (cand < 0 && req_valid[idx] && !m_busy[idx]) cand = idx;
                end
                eg = cand;
                if (cand >= 0 && pipe_v && req_setting[cand] != m_held) eg = -1;
                exp_rr  = (eg >= 0) ? N'(1 << eg) : '0;
                exp_in  = (eg >= 0) ? req_in[eg] : '0;
                exp_set = (eg >= 0) ? req_setting[eg] : (pipe_v ? m_held : 2'b00);
                chk("req_ready", 64'(req_ready), 64'(exp_rr));
                chk("pwl_in", 64'(pwl_in), 64'(exp_in));
                chk("pwl_setting", 64'(pwl_setting), 64'(exp_set));
                chk("rsp_valid", 64'(rsp_valid), 64'(m_rspv));
                for (int i = 0; i < N; i++)
                    if (m_rspv[i]) chk($sformatf("rsp_data[%0d]", i), 64'(rsp_data[i]), 64'(m_rspd[i]));
`ifdef PWL_ARB_STATS_EN
                for (int i = 0; i < N; i++)
                    chk($sformatf("grant_cnt[%0d]", i), 64'(grant_cnt[i]), 64'(m_cnt[i]));
`endif
                for (int i = 0; i < N; i++)
                    if (m_rspv[i] && rsp_ready[i]) begin m_rspv[i] = 1'b0; m_busy[i] = 1'b0; end
                if (pipe_v) begin m_rspv[pipe_id] = 1'b1; m_rspd[pipe_id] = pipe_res; end
                pipe_v = (eg >= 0);
                if (eg >= 0) begin
                    pipe_id    = eg;
                    pipe_res   = golden(req_in[eg], req_setting[eg]);
                    m_busy[eg] = 1'b1;
                    m_held     = req_setting[eg];
                    m_ptr      = (eg + 1) % N;
                    if (m_cnt[eg] < (1 << CNT_W) - 1) m_cnt[eg]++;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_valid = '0; rsp_ready = '1;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    function automatic int count_gid(input int from, input int n, input int id);
        int c = 0;
        for (int k = from; k < from + n; k++) if (k < GL && gid[k] == id) c++;
        return c;
    endfunction

    initial begin : watchdog
        #200000;
        errors++;
        $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : stimulus
        int c0;
        bit seen;
        req_valid = '0; req_in = '0; req_setting = '0; rsp_ready = '1;
        for (int k = 0; k < GL; k++) gid[k] = -1;
        step(3);
        rst_n = 1'b1;
        step(2);

        // Single request: accept at t, result visible at t+2
        req_in[0] = 16'h1234; req_setting[0] = 2'd1; req_valid[0] = 1'b1;
        seen = 1'b0;
        for (int b = 0; b < 10 && !seen; b++) begin
            @(negedge clk);
            if (req_ready[0]) seen = 1'b1;
        end
        chk("t2_accept", 64'(seen), 64'(1));
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("t2_rsp_t+1", 64'(rsp_valid[0]), 64'(0));
        @(negedge clk);
        chk("t2_rsp_t+2", 64'(rsp_valid[0]), 64'(1));
        chk("t2_rsp_data", 64'(rsp_data[0]), 64'(16'd458));
        step(3);

        // Reset with ops in flight
        rsp_ready = '0;
        req_in[0] = 16'h3456; req_in[1] = 16'h789A; req_setting[0] = 2'd3; req_setting[1] = 2'd3;
        req_valid = 4'b0011;
        step(2);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t1_rst_ready", 64'(req_ready), 64'(0));
        chk("t1_rst_rspv", 64'(rsp_valid), 64'(0));
        chk("t1_rst_pwl_in", 64'(pwl_in), 64'(0));
        step(1);
        req_valid = '0; rsp_ready = '1;
        rst_n = 1'b1;
        step(1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t1_no_late_rsp", 64'(rsp_valid), 64'(0));
        end
        step(1);

        // All four, same setting: 0,1,2,3 then 0
        for (int i = 0; i < N; i++) begin req_in[i] = 16'(16'h1100 * (i + 1) + i); req_setting[i] = 2'd0; end
        req_valid = '1;
        c0 = cyc + 1;
        step(10);
        req_valid = '0;
        for (int k = 0; k < 5; k++) chk($sformatf("t3_order[%0d]", k), 64'(gid[c0 + k]), 64'(k % N));
        step(4);

        // Setting hazard: grant 0, bubble, grant 1
        do_reset();
        req_in[0] = 16'h0000; req_setting[0] = 2'd0;
        req_in[1] = 16'h2010; req_setting[1] = 2'd2;
        req_valid = 4'b0011;
        c0 = cyc + 1;
        step(3);
        req_valid = '0;
        step(4);
        chk("t4_g0", 64'(gid[c0]), 64'(0));
        chk("t4_bubble", 64'(gid[c0 + 1]), 64'(-1));
        chk("t4_g1", 64'(gid[c0 + 2]), 64'(1));
        chk("t4_data0", 64'(rsp_data[0]), 64'(16'hFE0C));
        chk("t4_data1", 64'(rsp_data[1]), 64'(16'd1629));

        // Requester 2 stalled on response: never re-granted, others rotate past it
        do_reset();
        for (int i = 0; i < N; i++) begin req_in[i] = 16'(16'h4321 + 16'h0A05 * i); req_setting[i] = 2'd1; end
        req_valid = '1; rsp_ready = 4'b1011;
        c0 = cyc + 1;
        step(10);
        chk("t5_g2_once", 64'(count_gid(c0, 10, 2)), 64'(1));
        chk("t5_skip2", 64'(gid[c0 + 6]), 64'(3));
        chk("t5_rspv2_held", 64'(rsp_valid[2]), 64'(1));
        rsp_ready = '1;
        step(8);
        req_valid = '0;
        step(4);

        // Repeated accepts on requester 3 (counter saturation when stats are built in)
        do_reset();
        req_in[3] = 16'h5A5A; req_setting[3] = 2'd2; req_valid = 4'b1000;
        c0 = cyc + 1;
        step(13);
        req_valid = '0;
        step(2);
        chk("t6_accepts", 64'(count_gid(c0, 13, 3)), 64'(5));
`ifdef PWL_ARB_STATS_EN
        chk("t6_cnt5", 64'(grant_cnt[3]), 64'(5));
`endif
        req_valid = 4'b1000;
        step(12);
        req_valid = '0;
        step(2);
`ifdef PWL_ARB_STATS_EN
        chk("t6_cnt_sat", 64'(grant_cnt[3]), 64'(7));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
